fetch_pc_unit: RTL

Program-counter register and instruction-fetch sequencer. Sits directly downstream of the branch/next-PC logic: it holds the architectural PC, fetches the instruction at that PC from instruction memory over a req/ack handshake, presents the instruction to decode, and loads the next-PC value (PC+4 or jump target) once the current instruction is retired. It also detects misaligned next-PC values and halts.

---
 rtl/fetch_pc_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC, fetches the word at that PC over a req/ack
// handshake, presents it to decode and loads the next PC on retirement.
// A misaligned next PC parks the unit in a fault state. A halt request parks
// it in a halt state. Both states are left only through reset.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_RST    | post-reset dead cycles, no request
// S_REQ    | imem_req high with imem_addr=pc, waiting for imem_ack
// S_VALID  | instr/pc_out valid for decode, waiting for pc_load
// S_HALT   | halted on request, no further fetches
// S_FAULT  | misaligned pc_next seen, no further fetches
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        pc_load,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_REQ   = 3'd1,
    S_VALID = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;
  // S_RST is held for the first cycle after reset release as well, so the
  // first request appears two edges after rst_n is first sampled high.
  logic        rst_dead;

  // Fetch sequencer: state, PC, captured instruction and registered flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RST;
      rst_dead    <= 1'b0;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      fetch_count <= 32'h0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          if (rst_dead) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end else begin
            rst_dead <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            fetch_count <= fetch_count + 32'd1;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_VALID;
          end
        end
        S_VALID: begin
          if (pc_load) begin
            instr_valid <= 1'b0;
            // Misalignment wins over halt_req; PC keeps the faulting instruction.
            if (pc_next[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= S_FAULT;
            end else begin
              pc <= pc_next;
              if (halt_req) begin
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                imem_req <= 1'b1;
                state    <= S_REQ;
              end
            end
          end
        end
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: begin
          state       <= S_RST;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  // Address and PC output come straight from the PC register.
  assign imem_addr = pc;
  assign pc_out    = pc;

endmodule
